// File: rtl/axim_rd_arbiter_pkg.sv
// Shared types for the AXI-master read arbiter: FSM state encoding, stats counter
// width and an index-width helper.
package axim_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    XFER      = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_e;

  localparam int CNT_W = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axim_rd_arbiter_if.sv
// Bundle of requester-side and AXI-master-side signals of the read arbiter.
// master = arbiter view, slave = requesters + AXI read master view.
interface axim_rd_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int XFER_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_raddr_i;
  logic [NUM_REQ*XFER_WIDTH-1:0] req_xfer_size_i;
  logic [NUM_REQ-1:0]            req_ack_o;
  logic [NUM_REQ-1:0]            req_done_o;
  logic [DATA_WIDTH-1:0]         req_rd_tdata_o;
  logic [NUM_REQ-1:0]            req_rd_tvalid_o;
  logic                          req_rd_tlast_o;
  logic [NUM_REQ-1:0]            req_rd_tready_i;

  logic [ADDR_WIDTH-1:0]         ctrl_raddr_offset_o;
  logic [XFER_WIDTH-1:0]         ctrl_rxfer_size_o;
  logic                          ctrl_rstart_o;
  logic                          ctrl_rdone_i;
  logic [DATA_WIDTH-1:0]         rd_tdata_i;
  logic                          rd_tvalid_i;
  logic                          rd_tlast_i;
  logic                          rd_tready_o;

  logic                          busy_o;
  logic                          len_err_o;

  modport master (
    input  req_valid_i, req_raddr_i, req_xfer_size_i, req_rd_tready_i,
    input  ctrl_rdone_i, rd_tdata_i, rd_tvalid_i, rd_tlast_i,
    output req_ack_o, req_done_o, req_rd_tdata_o, req_rd_tvalid_o, req_rd_tlast_o,
    output ctrl_raddr_offset_o, ctrl_rxfer_size_o, ctrl_rstart_o, rd_tready_o,
    output busy_o, len_err_o
  );

  modport slave (
    output req_valid_i, req_raddr_i, req_xfer_size_i, req_rd_tready_i,
    output ctrl_rdone_i, rd_tdata_i, rd_tvalid_i, rd_tlast_i,
    input  req_ack_o, req_done_o, req_rd_tdata_o, req_rd_tvalid_o, req_rd_tlast_o,
    input  ctrl_raddr_offset_o, ctrl_rxfer_size_o, ctrl_rstart_o, rd_tready_o,
    input  busy_o, len_err_o
  );

endinterface

// File: rtl/axim_rd_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after the pointer,
// returned as one-hot grant plus index.
module rr_arbiter
  import axim_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               gnt_valid_o,
  output logic [NUM_REQ-1:0] gnt_onehot_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  always_comb begin
    int p;
    p            = 0;
    gnt_valid_o  = 1'b0;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      p = int'(ptr_i) + off;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      if (!gnt_valid_o && req_i[IDX_W'(p)]) begin
        gnt_valid_o                  = 1'b1;
        gnt_onehot_o[IDX_W'(p)]      = 1'b1;
        gnt_idx_o                    = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/axim_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-master read channel between NUM_REQ requesters.
// Optional per-requester grant counters when AXIM_RD_ARB_STATS_EN is defined.
//
// state     | meaning
// IDLE      | no transfer; arbitrate and latch winner's address/size
// START     | single-cycle ctrl_rstart_o pulse to the AXI master
// XFER      | read stream routed to the winner, beats counted
// WAIT_DONE | stream finished, waiting for (or already seen) ctrl_rdone_i
// DONE      | req_done_o pulse, advance round-robin pointer
module axim_rd_arbiter
  import axim_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int XFER_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  axim_rd_arbiter_if.master bus
`ifdef AXIM_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] grant_cnt_o
`endif
);

  localparam int IDX_W = idx_w(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    grant_oh_q, grant_oh_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XFER_WIDTH-1:0] size_q, size_d;
  logic [XFER_WIDTH-1:0] beat_q, beat_d;
  logic                  rdone_seen_q, rdone_seen_d;
  logic                  len_err_q, len_err_d;

  logic                  arb_valid;
  logic [NUM_REQ-1:0]    arb_oh;
  logic [IDX_W-1:0]      arb_idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [XFER_WIDTH-1:0] sel_size;
  logic                  tready;
  logic                  beat_fire;
  logic                  beat_is_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i        (bus.req_valid_i),
    .ptr_i        (rr_ptr_q),
    .gnt_valid_o  (arb_valid),
    .gnt_onehot_o (arb_oh),
    .gnt_idx_o    (arb_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_oh[i]) begin
        sel_addr = bus.req_raddr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_size = bus.req_xfer_size_i[i*XFER_WIDTH +: XFER_WIDTH];
      end
    end
  end

  assign tready       = (state_q == XFER) && |(bus.req_rd_tready_i & grant_oh_q);
  assign beat_fire    = tready && bus.rd_tvalid_i;
  assign beat_is_last = (beat_q == size_q - 1'b1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_oh_d   = grant_oh_q;
    addr_d       = addr_q;
    size_d       = size_q;
    beat_d       = beat_q;
    rdone_seen_d = rdone_seen_q;
    len_err_d    = len_err_q;
    rr_ptr_d     = rr_ptr_q;
    ack_d        = '0;
    unique case (state_q)
      IDLE: begin
        rdone_seen_d = 1'b0;
        beat_d       = '0;
        if (arb_valid) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          addr_d     = sel_addr;
          size_d     = sel_size;
          ack_d      = arb_oh;
          // zero-length requests complete without touching the AXI master
          state_d    = (sel_size == '0) ? DONE : START;
        end
      end
      START: begin
        if (bus.ctrl_rdone_i) rdone_seen_d = 1'b1;
        state_d = XFER;
      end
      XFER: begin
        if (bus.ctrl_rdone_i) rdone_seen_d = 1'b1;
        if (beat_fire) begin
          beat_d = beat_q + 1'b1;
          if (beat_is_last != bus.rd_tlast_i) len_err_d = 1'b1;
          if (beat_is_last || bus.rd_tlast_i) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.ctrl_rdone_i || rdone_seen_q) state_d = DONE;
      end
      DONE: begin
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      rr_ptr_q     <= '0;
      ack_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      beat_q       <= '0;
      rdone_seen_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_oh_q   <= grant_oh_d;
      rr_ptr_q     <= rr_ptr_d;
      ack_q        <= ack_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      beat_q       <= beat_d;
      rdone_seen_q <= rdone_seen_d;
      len_err_q    <= len_err_d;
    end
  end

  assign bus.req_ack_o           = ack_q;
  assign bus.req_done_o          = (state_q == DONE) ? grant_oh_q : '0;
  assign bus.req_rd_tdata_o      = bus.rd_tdata_i;
  assign bus.req_rd_tlast_o      = bus.rd_tlast_i;
  assign bus.req_rd_tvalid_o     = ((state_q == XFER) && bus.rd_tvalid_i) ? grant_oh_q : '0;
  assign bus.rd_tready_o         = tready;
  assign bus.ctrl_raddr_offset_o = addr_q;
  assign bus.ctrl_rxfer_size_o   = size_q;
  assign bus.ctrl_rstart_o       = (state_q == START);
  assign bus.busy_o              = (state_q != IDLE);
  assign bus.len_err_o           = len_err_q;

`ifdef AXIM_RD_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack_q[i] && (grant_cnt_q[i] != {CNT_W{1'b1}}))
          grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt_o[g*CNT_W +: CNT_W] = grant_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axim_rd_arbiter.sv
// Randomized bench for axim_rd_arbiter: emulates requesters and the AXI read master,
// checks against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_axim_rd_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int XW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axim_rd_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .XFER_WIDTH(XW), .DATA_WIDTH(DW)) bus ();

  axim_rd_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .XFER_WIDTH(XW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  int            m_rr = 0;
  logic [NR-1:0] m_pend = '0;
  logic          m_err = 1'b0;
  logic [AW-1:0] m_addr [NR];
  int            m_size [NR];
  int            m_tl   [NR];
  int            rstart_cnt = 0;

  always @(posedge clk) if (bus.ctrl_rstart_o === 1'b1) rstart_cnt++;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model_pick();
    for (int off = 0; off < NR; off++)
      if (m_pend[(m_rr + off) % NR]) return (m_rr + off) % NR;
    return -1;
  endfunction

  task automatic post(input int i, input logic [AW-1:0] a, input int sz, input int tl);
    m_addr[i] = a;
    m_size[i] = sz;
    m_tl[i]   = tl;
    m_pend[i] = 1'b1;
    bus.req_raddr_i[i*AW +: AW]     = a;
    bus.req_xfer_size_i[i*XW +: XW] = sz;
    bus.req_valid_i[i]              = 1'b1;
  endtask

  task automatic withdraw(input int i);
    m_pend[i]          = 1'b0;
    bus.req_valid_i[i] = 1'b0;
  endtask

  task automatic post_random(input int i);
    int sz;
    int tl;
    sz = $urandom_range(0, 6);
    tl = sz - 1;
    if (sz > 0 && $urandom_range(0, 3) == 0) tl = $urandom_range(0, sz + 1);
    post(i, $urandom, sz, tl);
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_ack"},    bus.req_ack_o, '0);
    check_val({pfx, "_done"},   bus.req_done_o, '0);
    check_val({pfx, "_rstart"}, bus.ctrl_rstart_o, 0);
    check_val({pfx, "_busy"},   bus.busy_o, 0);
    check_val({pfx, "_lenerr"}, bus.len_err_o, 0);
    check_val({pfx, "_tvalid"}, bus.req_rd_tvalid_o, '0);
    check_val({pfx, "_tready"}, bus.rd_tready_o, 0);
    check_val({pfx, "_addr"},   bus.ctrl_raddr_offset_o, '0);
    check_val({pfx, "_size"},   bus.ctrl_rxfer_size_o, '0);
  endtask

  // Serves the model's expected winner end to end; returns at the negedge of its done pulse.
  task automatic serve(input int exp_lat, input int rdone_arg, input bit directed, output int w);
    int sz, tl, exit_at, lat, beats, cyc, last_cyc, exp_done, got, r0, rdone_pos;
    logic vld, tr, tl_bit;
    logic [DW-1:0] dv;
    logic [NR-1:0] oh;
    w = model_pick();
    if (w < 0) return;
    oh = '0;
    oh[w] = 1'b1;
    sz = m_size[w];
    tl = m_tl[w];
    r0 = rstart_cnt;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.req_ack_o == '0 && lat < 20);
    check_val("ack_lat", lat, exp_lat);
    check_val("ack_vec", bus.req_ack_o, oh);
    check_val("busy", bus.busy_o, 1);
    withdraw(w);
    if (sz == 0) begin
      check_val("zero_rstart", bus.ctrl_rstart_o, 0);
      check_val("zero_done", bus.req_done_o, oh);
      m_rr = (w + 1) % NR;
      return;
    end
    check_val("rstart", bus.ctrl_rstart_o, 1);
    check_val("addr", bus.ctrl_raddr_offset_o, m_addr[w]);
    check_val("size", bus.ctrl_rxfer_size_o, sz);

    exit_at   = (tl < sz - 1) ? tl : sz - 1;
    rdone_pos = (rdone_arg < 0) ? $urandom_range(0, exit_at + 3) : rdone_arg;
    beats = 0;
    cyc = 0;
    last_cyc = 0;
    while ((beats <= exit_at || cyc <= rdone_pos) && cyc < 200) begin
      @(negedge clk);
      bus.ctrl_rdone_i = (cyc == rdone_pos);
      if (directed) begin
        vld = (beats <= exit_at);
        tr  = !(cyc == 1 || cyc == 2);
      end else begin
        vld = (beats <= exit_at) && ($urandom_range(0, 3) != 0);
        tr  = ($urandom_range(0, 3) != 0);
      end
      tl_bit = vld && (beats == tl);
      dv = $urandom;
      bus.rd_tvalid_i        = vld;
      bus.rd_tdata_i         = dv;
      bus.rd_tlast_i         = tl_bit;
      bus.req_rd_tready_i    = NR'($urandom);
      bus.req_rd_tready_i[w] = tr;
      #1;
      check_val("tready", bus.rd_tready_o, (beats <= exit_at) ? tr : 1'b0);
      check_val("tvalid_vec", bus.req_rd_tvalid_o, (beats <= exit_at && vld) ? oh : '0);
      check_val("tdata_bc", bus.req_rd_tdata_o, dv);
      check_val("tlast_bc", bus.req_rd_tlast_o, tl_bit);
      check_val("early_done", bus.req_done_o, '0);
      if (beats <= exit_at && vld && tr) begin
        last_cyc = cyc;
        beats++;
      end
      cyc++;
    end
    if (tl != sz - 1) m_err = 1'b1;
    exp_done = (last_cyc + 2 > rdone_pos + 1) ? last_cyc + 2 : rdone_pos + 1;
    got = -1;
    while (got < 0 && cyc < exp_done + 10) begin
      @(negedge clk);
      bus.ctrl_rdone_i = 1'b0;
      bus.rd_tvalid_i  = 1'b0;
      bus.rd_tlast_i   = 1'b0;
      if (bus.req_done_o != '0) got = cyc;
      else cyc++;
    end
    check_val("done_cyc", got, exp_done);
    check_val("done_vec", bus.req_done_o, oh);
    check_val("len_err", bus.len_err_o, m_err);
    check_val("rstart_cnt", rstart_cnt - r0, 1);
    m_rr = (w + 1) % NR;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    int w, lat;
    int served [NR];
    bit first;
    logic [NR-1:0] oh;

    reset = 1'b1;
    bus.req_valid_i     = '0;
    bus.req_raddr_i     = '0;
    bus.req_xfer_size_i = '0;
    bus.req_rd_tready_i = '0;
    bus.ctrl_rdone_i    = 1'b0;
    bus.rd_tdata_i      = '0;
    bus.rd_tvalid_i     = 1'b0;
    bus.rd_tlast_i      = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single transfer from requester 0
    post(0, 32'h1000, 4, 3);
    serve(1, -1, 1'b0, w);
    repeat (2) @(negedge clk);

    // two held requesters alternate
    for (int i = 0; i < NR; i++) served[i] = 0;
    post(0, 32'h1100, 2, 1);
    post(1, 32'h1200, 3, 2);
    for (int k = 0; k < 6; k++) begin
      serve((k == 0) ? 1 : 2, -1, 1'b0, w);
      served[w]++;
      if (served[w] < 3) post(w, $urandom, $urandom_range(1, 3), -2);
      if (w >= 0 && m_size[w] > 0 && m_tl[w] == -2) begin
        m_tl[w] = m_size[w] - 1;
      end
    end
    check_val("alt_cnt0", served[0], 3);
    check_val("alt_cnt1", served[1], 3);
    repeat (2) @(negedge clk);

    // zero-size request
    post(1, 32'h2000, 0, -1);
    serve(1, -1, 1'b0, w);
    repeat (2) @(negedge clk);

    // early rdone with backpressure
    post(0, 32'h3000, 4, 3);
    serve(1, 4, 1'b1, w);
    repeat (2) @(negedge clk);

    // tlast before size-1 sets sticky length error
    post(1, 32'h4000, 8, 5);
    serve(1, -1, 1'b0, w);
    repeat (3) @(negedge clk);
    check_val("len_err_sticky", bus.len_err_o, m_err);

    // randomized traffic
    first = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NR; i++) begin
        if (!m_pend[i] && $urandom_range(0, 1) == 1) post_random(i);
        else if (m_pend[i] && $urandom_range(0, 9) == 0) withdraw(i);
      end
      if (m_pend == '0) post_random($urandom_range(0, NR - 1));
      serve(first ? 1 : 2, -1, 1'b0, w);
      first = 1'b0;
    end
    for (int i = 0; i < NR; i++) if (m_pend[i]) withdraw(i);
    repeat (3) @(negedge clk);
    check_val("idle_busy", bus.busy_o, 0);

    // move pointer off requester 0, then reset in the middle of a transfer
    post(0, 32'h4800, 2, 1);
    serve(1, -1, 1'b0, w);
    repeat (2) @(negedge clk);
    post(1, 32'h5000, 6, 5);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.req_ack_o == '0 && lat < 20);
    oh = '0;
    oh[model_pick()] = 1'b1;
    check_val("rst_ack", bus.req_ack_o, oh);
    withdraw(1);
    @(negedge clk);
    bus.rd_tvalid_i     = 1'b1;
    bus.rd_tdata_i      = 32'hA5A5_0001;
    bus.req_rd_tready_i = '1;
    #1;
    check_val("rst_xfer_tready", bus.rd_tready_o, 1);
    @(negedge clk);
    reset = 1'b1;
    bus.rd_tvalid_i     = 1'b0;
    bus.rd_tdata_i      = '0;
    bus.req_rd_tready_i = '0;
    @(negedge clk);
    check_all_zero("midrst");
    @(negedge clk);
    check_val("midrst_done", bus.req_done_o, '0);
    reset  = 1'b0;
    m_rr   = 0;
    m_err  = 1'b0;
    m_pend = '0;
    repeat (2) @(negedge clk);
    check_val("post_rst_done", bus.req_done_o, '0);
    post(0, 32'h6000, 3, 2);
    post(1, 32'h7000, 2, 1);
    serve(1, -1, 1'b0, w);
    check_val("post_rst_winner", w, 0);
    serve(2, -1, 1'b0, w);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
